// File: rtl/pc_gen_unit.sv
// RV32I fetch-stage program-counter generator: trap/redirect/pending/sequential next-PC selection.
// Optional build macro PC_MISALIGN_CHK_EN rejects and flags misaligned redirect targets.
module pc_gen_unit #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned          PC_INC       = 4,
    parameter int unsigned          ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic            redirect_pending,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
    localparam logic [XLEN-1:0] INC        = XLEN'(PC_INC);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_is_trap_q, pend_is_trap_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;

    logic            advance;
    logic            redir_ok;
    logic            redir_bad;
    logic [XLEN-1:0] trap_aligned;
    logic [XLEN-1:0] redir_aligned;

    assign advance       = pc_valid_q & pc_write & fetch_ready;
    assign trap_aligned  = trap_target & ALIGN_MASK;
    assign redir_aligned = redirect_target & ALIGN_MASK;

`ifdef PC_MISALIGN_CHK_EN
    // Misaligned redirects are dropped entirely and reported one cycle later.
    assign redir_bad = redirect_valid & (|(redirect_target & ~ALIGN_MASK));
`else
    assign redir_bad = 1'b0;
`endif
    assign redir_ok = redirect_valid & ~redir_bad;

    // State, PC and pending-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= BOOT;
            pc_q           <= RESET_VECTOR;
            pend_target_q  <= '0;
            pend_is_trap_q <= 1'b0;
            pc_valid_q     <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_target_q  <= pend_target_d;
            pend_is_trap_q <= pend_is_trap_d;
            pc_valid_q     <= pc_valid_d;
            misalign_q     <= misalign_d;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_target_d  = pend_target_q;
        pend_is_trap_d = pend_is_trap_q;
        misalign_d     = redir_bad;

        if (advance) begin
            state_d        = RUN;
            pend_is_trap_d = 1'b0;
            if (trap_valid) begin
                pc_d = trap_aligned;
            end else if (redir_ok) begin
                pc_d = redir_aligned;
            end else if (state_q == HOLD) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + INC;
            end
        end else begin
            if (state_q == BOOT) begin
                state_d = RUN;
            end
            // A buffered trap is never displaced by a later redirect.
            if (trap_valid) begin
                pend_target_d  = trap_aligned;
                pend_is_trap_d = 1'b1;
                state_d        = HOLD;
            end else if (redir_ok && !(state_q == HOLD && pend_is_trap_q)) begin
                pend_target_d  = redir_aligned;
                pend_is_trap_d = 1'b0;
                state_d        = HOLD;
            end
        end

        pc_valid_d = (state_d != BOOT);
    end

    assign pc_out           = pc_q;
    assign pc_valid         = pc_valid_q;
    assign pc_plus_inc      = pc_q + INC;
    assign redirect_pending = (state_q == HOLD);
    assign misalign_err     = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: default-vector instance plus a wrap-around instance.
// Expectations for misaligned redirects follow PC_MISALIGN_CHK_EN.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic [31:0] trap_target;

    logic [31:0] pc_a, inc_a, pc_b, inc_b;
    logic        valid_a, pend_a, mis_a, valid_b, pend_b, mis_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pc_gen_unit u_dut_a (
        .clk(clk), .rst(rst), .pc_write(pc_write), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .pc_out(pc_a), .pc_valid(valid_a), .pc_plus_inc(inc_a),
        .redirect_pending(pend_a), .misalign_err(mis_a)
    );

    pc_gen_unit #(.RESET_VECTOR(32'hFFFF_FFF8)) u_dut_b (
        .clk(clk), .rst(rst), .pc_write(pc_write), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .trap_valid(trap_valid), .trap_target(trap_target),
        .pc_out(pc_b), .pc_valid(valid_b), .pc_plus_inc(inc_b),
        .redirect_pending(pend_b), .misalign_err(mis_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pc_write = 1'b0; fetch_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        trap_valid = 1'b0; trap_target = '0;
        #2 rst = 1'b0;
        step();
        check("rst_pc",    pc_a, 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_pend",  32'(pend_a), 32'h0);
        check("rst_mis",   32'(mis_a), 32'h0);
        check("rst_pc_b",  pc_b, 32'hFFFF_FFF8);

        // 1: boot and sequential fetch
        pc_write = 1'b1; fetch_ready = 1'b1; rst = 1'b1;
        step();
        check("boot_pc",    pc_a, 32'h0);
        check("boot_valid", 32'(valid_a), 32'h1);
        step(); check("seq_4", pc_a, 32'h4);
        step(); check("seq_8", pc_a, 32'h8);
        check("plus_inc", inc_a, 32'hC);

        // 2: stall holds PC
        pc_write = 1'b0;
        step(); check("stall_1", pc_a, 32'h8);
        step(); check("stall_2", pc_a, 32'h8);
        pc_write = 1'b1;
        step(); check("resume", pc_a, 32'hC);
        fetch_ready = 1'b0;
        step(); check("backpressure", pc_a, 32'hC);
        fetch_ready = 1'b1;

        // 3: redirect while advancing
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step(); check("redir", pc_a, 32'h100);
        redirect_valid = 1'b0;
        step(); check("redir_seq", pc_a, 32'h104);

        // 4: redirect during stall is buffered
        pc_write = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        check("buf_pc",   pc_a, 32'h104);
        check("buf_pend", 32'(pend_a), 32'h1);
        redirect_valid = 1'b0;
        step(); check("buf_hold", pc_a, 32'h104);
        pc_write = 1'b1;
        step();
        check("buf_apply", pc_a, 32'h200);
        check("buf_clear", 32'(pend_a), 32'h0);

        // 5: trap beats redirect; pending trap survives a later redirect
        trap_valid = 1'b1; trap_target = 32'h80;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step(); check("trap_prio", pc_a, 32'h80);
        pc_write = 1'b0; redirect_valid = 1'b0; trap_target = 32'h40;
        step(); check("trap_buf", 32'(pend_a), 32'h1);
        trap_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h300;
        step(); check("trap_keep_pc", pc_a, 32'h80);
        redirect_valid = 1'b0; pc_write = 1'b1;
        step(); check("trap_apply", pc_a, 32'h40);

        // pending redirect overwritten by newer redirect
        pc_write = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h500;
        step();
        redirect_target = 32'h600;
        step();
        redirect_valid = 1'b0; pc_write = 1'b1;
        step(); check("redir_overwrite", pc_a, 32'h600);

        // trap target low bits cleared
        trap_valid = 1'b1; trap_target = 32'h83;
        step(); check("trap_align", pc_a, 32'h80);
        trap_valid = 1'b0;

        // reset during HOLD discards pending target
        pc_write = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h700;
        step(); check("hold_pend", 32'(pend_a), 32'h1);
        redirect_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_pc",    pc_a, 32'h0);
        check("mid_rst_valid", 32'(valid_a), 32'h0);
        check("mid_rst_pend",  32'(pend_a), 32'h0);
        step();
        rst = 1'b1; pc_write = 1'b1;
        step(); check("reboot_pc", pc_a, 32'h0);
        step(); check("reboot_seq", pc_a, 32'h4);

        // 6: wrap-around and misaligned redirect on the high-vector instance
        rst = 1'b0;
        step();
        rst = 1'b1;
        step(); check("wrap_boot", pc_b, 32'hFFFF_FFF8);
        step();
        check("wrap_fffc", pc_b, 32'hFFFF_FFFC);
        check("wrap_inc",  inc_b, 32'h0);
        step(); check("wrap_0", pc_b, 32'h0);
        redirect_valid = 1'b1; redirect_target = 32'h102;
        step();
`ifdef PC_MISALIGN_CHK_EN
        check("mis_pc",  pc_b, 32'h4);
        check("mis_err", 32'(mis_b), 32'h1);
`else
        check("mis_pc",  pc_b, 32'h100);
        check("mis_err", 32'(mis_b), 32'h0);
`endif
        redirect_valid = 1'b0;
        step();
`ifdef PC_MISALIGN_CHK_EN
        check("mis_pc_next", pc_b, 32'h8);
`else
        check("mis_pc_next", pc_b, 32'h104);
`endif
        check("mis_err_clr", 32'(mis_b), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
